qpu_exu_measure_collect: RTL and testbench

//  Collects per-qubit readout results for one measurement instruction. Results arrive

---
 rtl/qpu_exu_measure_collect_if.sv | 28 ++
 rtl/qpu_exu_measure_collect.sv | 91 +++++++++
 tb/tb_qpu_exu_measure_collect.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpu_exu_measure_collect_if.sv
// Request/readout/result bundle between the MCU readout side, the issuing pipe and the
// measurement collector; the collector takes the slave side.
interface qpu_exu_measure_collect_if #(
   parameter int unsigned QUBIT_NUM = 12
);
   logic                 meas_req_valid;
   logic [QUBIT_NUM-1:0] meas_req_list;
   logic                 meas_req_ready;
   logic [QUBIT_NUM-1:0] rd_valid;
   logic [QUBIT_NUM-1:0] rd_data;
   logic                 mcu_measure_o_wen;
   logic [QUBIT_NUM-1:0] mcu_measure_o_data;
   logic [QUBIT_NUM-1:0] mcu_measure_o_list;
   logic                 timeout_o;
   logic                 busy_o;

   modport master (
      output meas_req_valid, meas_req_list, rd_valid, rd_data,
      input  meas_req_ready, mcu_measure_o_wen, mcu_measure_o_data, mcu_measure_o_list,
      input  timeout_o, busy_o
   );

   modport slave (
      input  meas_req_valid, meas_req_list, rd_valid, rd_data,
      output meas_req_ready, mcu_measure_o_wen, mcu_measure_o_data, mcu_measure_o_list,
      output timeout_o, busy_o
   );
endinterface

// File: rtl/qpu_exu_measure_collect.sv
// Gathers per-qubit readout results for one measurement and emits a single-cycle regfile
// write once all requested qubits have reported or the timeout expires.
module qpu_exu_measure_collect #(
   parameter int unsigned QUBIT_NUM      = 12,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned CNT_W          = 16
) (
   input logic                      clk,
   input logic                      rst,
   qpu_exu_measure_collect_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

   state_e               state_q, state_d;
   logic [QUBIT_NUM-1:0] pending_q, pending_d;
   logic [QUBIT_NUM-1:0] got_q, got_d;
   logic [QUBIT_NUM-1:0] data_q, data_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 tmo_q, tmo_d;

   logic [QUBIT_NUM-1:0] capture;
   logic [QUBIT_NUM-1:0] got_nxt;

   // Only the first strobe of a pending qubit is captured.
   assign capture = bus.rd_valid & pending_q & ~got_q;
   assign got_nxt = got_q | (bus.rd_valid & pending_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= '0;
         got_q     <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         got_q     <= got_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      got_d     = got_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      unique case (state_q)
         StIdle: begin
            // An empty list is accepted and dropped without leaving idle.
            if (bus.meas_req_valid && (|bus.meas_req_list)) begin
               pending_d = bus.meas_req_list;
               got_d     = '0;
               data_d    = '0;
               cnt_d     = '0;
               tmo_d     = 1'b0;
               state_d   = StCollect;
            end
         end
         StCollect: begin
            data_d = (data_q & ~capture) | (bus.rd_data & capture);
            got_d  = got_nxt;
            if (got_nxt == pending_q) begin
               tmo_d   = 1'b0;
               state_d = StWrite;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               tmo_d   = 1'b1;
               state_d = StWrite;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWrite: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign bus.meas_req_ready     = (state_q == StIdle);
   assign bus.busy_o             = (state_q != StIdle);
   assign bus.mcu_measure_o_wen  = (state_q == StWrite);
   assign bus.mcu_measure_o_data = (state_q == StWrite) ? data_q : '0;
   assign bus.mcu_measure_o_list = (state_q == StWrite) ? pending_q : '0;
   assign bus.timeout_o          = (state_q == StWrite) && tmo_q;

endmodule

// File: tb/tb_qpu_exu_measure_collect.sv
// Directed bench for the measurement collector: a cycle-indexed transaction model checked
// every cycle, plus literal expectations for each scenario.
module tb_qpu_exu_measure_collect;
   localparam int unsigned QN   = 12;
   localparam int unsigned TOUT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qpu_exu_measure_collect_if #(.QUBIT_NUM(QN)) bus ();

   qpu_exu_measure_collect #(
      .QUBIT_NUM      (QN),
      .TIMEOUT_CYCLES (TOUT),
      .CNT_W          (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_pass = 0;
   int n_total = 0;
   int cur_cyc = 0;

   always @(posedge clk) cur_cyc <= cur_cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cur_cyc);
   endtask

   // Model: a transaction starts collecting the cycle after acceptance and its write lands
   // one cycle after the last needed result, or TOUT cycles after collection began.
   logic          m_active = 1'b0;
   int            m_start = 0;
   int            m_write = -1;
   logic [QN-1:0] m_pending = '0, m_got = '0, m_data = '0;
   logic          m_tmo = 1'b0;

   int            wen_cnt = 0;
   int            last_wen_cyc = -1;

   initial begin
      forever begin
         int   c;
         logic e_wen;
         @(negedge clk);
         c     = cur_cyc;
         e_wen = m_active && (m_write == c);
         if (c > 0) begin
            chk("wen",   32'(bus.mcu_measure_o_wen),  32'(e_wen));
            chk("data",  32'(bus.mcu_measure_o_data), e_wen ? 32'(m_data) : 32'h0);
            chk("list",  32'(bus.mcu_measure_o_list), e_wen ? 32'(m_pending) : 32'h0);
            chk("tmo",   32'(bus.timeout_o),          32'(e_wen && m_tmo));
            chk("busy",  32'(bus.busy_o),             32'(m_active));
            chk("ready", 32'(bus.meas_req_ready),     32'(!m_active));
         end
         if (bus.mcu_measure_o_wen === 1'b1) begin
            wen_cnt++;
            last_wen_cyc = c;
         end
         if (rst) begin
            m_active = 1'b0;
            m_write  = -1;
         end else if (!m_active) begin
            if (bus.meas_req_valid && bus.meas_req_list != '0) begin
               m_active  = 1'b1;
               m_pending = bus.meas_req_list;
               m_got     = '0;
               m_data    = '0;
               m_tmo     = 1'b0;
               m_start   = c + 1;
               m_write   = -1;
            end
         end else if (m_write == c) begin
            m_active = 1'b0;
            m_write  = -1;
         end else begin
            for (int k = 0; k < int'(QN); k++) begin
               if (bus.rd_valid[k] && m_pending[k] && !m_got[k]) begin
                  m_got[k]  = 1'b1;
                  m_data[k] = bus.rd_data[k];
               end
            end
            if (m_got == m_pending) begin
               m_write = c + 1;
               m_tmo   = 1'b0;
            end else if (c - m_start + 1 == int'(TOUT)) begin
               m_write = c + 1;
               m_tmo   = 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic peek();
      #3;
   endtask

   task automatic strobe(input logic [QN-1:0] v, input logic [QN-1:0] d);
      bus.rd_valid = v;
      bus.rd_data  = d;
   endtask

   task automatic request(input logic [QN-1:0] list);
      bus.meas_req_valid = 1'b1;
      bus.meas_req_list  = list;
      step();
      bus.meas_req_valid = 1'b0;
      bus.meas_req_list  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, e, n0;
      bus.meas_req_valid = 1'b0;
      bus.meas_req_list  = '0;
      bus.rd_valid       = '0;
      bus.rd_data        = '0;

      // 1: reset
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      peek();
      chk("rst_wen",   32'(bus.mcu_measure_o_wen), 32'h0);
      chk("rst_ready", 32'(bus.meas_req_ready),    32'h1);
      chk("rst_busy",  32'(bus.busy_o),            32'h0);
      step();

      // 2: two staggered results
      request(12'h005);
      t = cur_cyc;
      strobe(12'h001, 12'h001);
      step();
      strobe('0, '0);
      step();
      strobe(12'h004, 12'h000);
      step();
      strobe('0, '0);
      peek();
      chk("t2_wen",  32'(bus.mcu_measure_o_wen),  32'h1);
      chk("t2_data", 32'(bus.mcu_measure_o_data), 32'h001);
      chk("t2_list", 32'(bus.mcu_measure_o_list), 32'h005);
      chk("t2_tmo",  32'(bus.timeout_o),          32'h0);
      step();
      chk("t2_at",   32'(last_wen_cyc), 32'(t + 3));
      chk("t2_once", 32'(wen_cnt),      32'h1);

      // 3: same-cycle results, stray and duplicate strobes
      request(12'h005);
      strobe(12'h00d, 12'h00c);
      step();
      strobe(12'h005, 12'h001);
      peek();
      chk("t3_wen",  32'(bus.mcu_measure_o_wen),  32'h1);
      chk("t3_data", 32'(bus.mcu_measure_o_data), 32'h004);
      step();
      strobe('0, '0);
      step();

      // 4: timeout with one result missing
      request(12'h003);
      e = cur_cyc;
      strobe(12'h002, 12'h002);
      step();
      strobe('0, '0);
      repeat (int'(TOUT) - 1) step();
      peek();
      chk("t4_wen",  32'(bus.mcu_measure_o_wen),  32'h1);
      chk("t4_at",   32'(cur_cyc),                32'(e + 8));
      chk("t4_data", 32'(bus.mcu_measure_o_data), 32'h002);
      chk("t4_list", 32'(bus.mcu_measure_o_list), 32'h003);
      chk("t4_tmo",  32'(bus.timeout_o),          32'h1);
      step();

      // 4b: final result lands on the last collect cycle
      request(12'h003);
      e = cur_cyc;
      strobe(12'h002, 12'h002);
      step();
      strobe('0, '0);
      repeat (int'(TOUT) - 2) step();
      strobe(12'h001, 12'h001);
      step();
      strobe('0, '0);
      peek();
      chk("t4b_at",   32'(cur_cyc),                32'(e + 8));
      chk("t4b_wen",  32'(bus.mcu_measure_o_wen),  32'h1);
      chk("t4b_data", 32'(bus.mcu_measure_o_data), 32'h003);
      chk("t4b_tmo",  32'(bus.timeout_o),          32'h0);
      step();

      // 5: held second request, then an empty request
      request(12'h001);
      bus.meas_req_valid = 1'b1;
      bus.meas_req_list  = 12'h002;
      strobe(12'h001, 12'h000);
      peek();
      chk("t5_ready_col", 32'(bus.meas_req_ready), 32'h0);
      step();
      strobe('0, '0);
      peek();
      chk("t5_ready_wr", 32'(bus.meas_req_ready), 32'h0);
      step();
      peek();
      chk("t5_ready_idle", 32'(bus.meas_req_ready), 32'h1);
      step();
      bus.meas_req_valid = 1'b0;
      bus.meas_req_list  = '0;
      peek();
      chk("t5_busy2", 32'(bus.busy_o), 32'h1);
      strobe(12'h002, 12'h002);
      step();
      strobe('0, '0);
      peek();
      chk("t5_data2", 32'(bus.mcu_measure_o_data), 32'h002);
      chk("t5_list2", 32'(bus.mcu_measure_o_list), 32'h002);
      step();
      n0 = wen_cnt;
      request(12'h000);
      peek();
      chk("t5_empty_busy", 32'(bus.busy_o), 32'h0);
      repeat (3) step();
      chk("t5_empty_wen", 32'(wen_cnt), 32'(n0));

      // 6: reset mid-collect
      request(12'h003);
      strobe(12'h001, 12'h001);
      step();
      strobe('0, '0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      peek();
      chk("t6_busy",  32'(bus.busy_o),         32'h0);
      chk("t6_ready", 32'(bus.meas_req_ready), 32'h1);
      repeat (TOUT + 2) step();
      chk("t6_nowen", 32'(wen_cnt), 32'(n0));
      request(12'h003);
      strobe(12'h003, 12'h000);
      step();
      strobe('0, '0);
      peek();
      chk("t6_wen",  32'(bus.mcu_measure_o_wen),  32'h1);
      chk("t6_data", 32'(bus.mcu_measure_o_data), 32'h000);
      chk("t6_list", 32'(bus.mcu_measure_o_list), 32'h003);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
